mouse_axis_emu: RTL and testbench

Converts PS/2 mouse movement packets from the HPS bridge into Atari analog axis values and a digital port byte for joystick port 1, feeding the JOY1X/JOY1Y/JOY1 inputs of the Atari core.
- Each mouse packet's deltas are limited, accumulated into signed 8-bit axis positions and clamped.
- A real analog joystick or a CPU halt immediately returns port 1 to pass-through of the HPS joystick 0 signals.
- The block sits between the HPS I/O decoder and the core top.

---
 rtl/mouse_axis_emu_if.sv | 13 +
 rtl/mouse_axis_emu.sv | 73 +++++++
 tb/tb_mouse_axis_emu.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mouse_axis_emu_if.sv
// mouse_axis_emu_if: HPS-side mouse/joystick inputs and core-side port 1 outputs.
interface mouse_axis_emu_if;
   logic [24:0] ps2_mouse;
   logic [15:0] joya;
   logic [7:0]  joy;
   logic        halt;
   logic [7:0]  ax;
   logic [7:0]  ay;
   logic [7:0]  j_out;
   logic        mouse_active;
   modport master (output ps2_mouse, joya, joy, halt, input ax, ay, j_out, mouse_active);
   modport slave  (input ps2_mouse, joya, joy, halt, output ax, ay, j_out, mouse_active);
endinterface

// File: rtl/mouse_axis_emu.sv
// mouse_axis_emu: accumulates PS/2 mouse deltas into Atari analog axes for joystick port 1,
// falling back to joystick 0 pass-through on analog activity, halt or idle timeout.
module mouse_axis_emu #(
   parameter int DELTA_MAX   = 10,
   parameter int IDLE_CYCLES = 0
) (
   input  logic clk_sys,
   input  logic reset,
   mouse_axis_emu_if.slave bus
);
   typedef enum logic {PASS, MOUSE} mode_t;
   localparam int CW = IDLE_CYCLES > 1 ? $clog2(IDLE_CYCLES) : 1;
   localparam logic signed [8:0] LIM = 9'(DELTA_MAX);

   mode_t                mode;
   logic                 stb_q, v1, pkt, rel, tmo;
   logic signed [8:0]    dx, dy, dx1, dy1, nx, ny;
   logic signed [7:0]    mx, my;
   logic        [CW-1:0] idle;

   function automatic logic signed [8:0] lim(input logic signed [8:0] d);
      return d > LIM ? LIM : d < -LIM ? -LIM : d;
   endfunction

   function automatic logic signed [7:0] sat(input logic signed [8:0] n);
      return n > 9'sd127 ? 8'h7f : n < -9'sd128 ? 8'h80 : n[7:0];
   endfunction

   assign pkt = bus.ps2_mouse[24] ^ stb_q;
   assign rel = (|bus.joya) | bus.halt;
   // Magnitude is halved by dropping its LSB and sign-extending twice.
   assign dx  = {bus.ps2_mouse[4], bus.ps2_mouse[4], bus.ps2_mouse[15:9]};
   assign dy  = {bus.ps2_mouse[5], bus.ps2_mouse[5], bus.ps2_mouse[23:17]};
   assign nx  = {mx[7], mx} + dx1;
   assign ny  = {my[7], my} + dy1;
   assign tmo = IDLE_CYCLES > 0 && mode == MOUSE && !v1 && idle == CW'(IDLE_CYCLES - 1);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         mode  <= PASS;
         stb_q <= bus.ps2_mouse[24];
         v1    <= 1'b0;
         dx1   <= '0;
         dy1   <= '0;
         mx    <= '0;
         my    <= '0;
         idle  <= '0;
      end else begin
         stb_q <= bus.ps2_mouse[24];
         v1    <= pkt & ~rel;
         dx1   <= lim(dx);
         dy1   <= lim(dy);
         if (rel || tmo) begin
            mode <= PASS;
            mx   <= '0;
            my   <= '0;
            idle <= '0;
         end else if (v1) begin
            mode <= MOUSE;
            mx   <= sat(nx);
            my   <= sat(ny);
            idle <= '0;
         end else if (mode == MOUSE && IDLE_CYCLES > 0) begin
            idle <= idle + 1'b1;
         end
      end
   end

   assign bus.mouse_active = mode == MOUSE;
   assign bus.ax    = mode == MOUSE ? mx : bus.joya[7:0];
   assign bus.ay    = mode == MOUSE ? my : bus.joya[15:8];
   assign bus.j_out = mode == MOUSE ? {bus.joy[7], bus.ps2_mouse[1:0], bus.joy[4:0]} : bus.joy;
endmodule

// File: tb/tb_mouse_axis_emu.sv
// tb_mouse_axis_emu: directed checks of mouse accumulation, clamping, release and idle timeout.
module tb_mouse_axis_emu;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   mouse_axis_emu_if i0 ();
   mouse_axis_emu_if i1 ();

   assign i1.ps2_mouse = i0.ps2_mouse;
   assign i1.joya      = i0.joya;
   assign i1.joy       = i0.joy;
   assign i1.halt      = i0.halt;

   mouse_axis_emu u0 (.clk_sys(clk), .reset(rst), .bus(i0));
   mouse_axis_emu #(.IDLE_CYCLES(100)) u1 (.clk_sys(clk), .reset(rst), .bus(i1));

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pkt(input logic sx, input logic [7:0] xm, input logic sy, input logic [7:0] ym,
                      input logic [1:0] btn);
      i0.ps2_mouse = {~i0.ps2_mouse[24], ym, xm, 2'b00, sy, sx, 2'b00, btn};
   endtask

   task automatic test_reset;
      i0.ps2_mouse = '0;
      i0.joya = 16'h0000;
      i0.joy  = 8'hA5;
      i0.halt = 1'b0;
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(1);
      checks++; if (i0.mouse_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", i0.mouse_active); end
      checks++; if (i0.j_out !== 8'hA5) begin errors++; $display("FAIL reset_jout got %h want a5", i0.j_out); end
      i0.joya = 16'h1234;
      step(1);
      checks++; if ({i0.ay, i0.ax} !== 16'h1234) begin errors++; $display("FAIL reset_pass_axes got %h want 1234", {i0.ay, i0.ax}); end
      i0.joya = 16'h0000;
      step(1);
   endtask

   task automatic test_single;
      pkt(1'b0, 8'h28, 1'b0, 8'h00, 2'b10);
      step(1);
      checks++; if (i0.mouse_active !== 1'b0 || i0.ax !== 8'h00) begin errors++; $display("FAIL latency_early got act=%b ax=%h want 0 00", i0.mouse_active, i0.ax); end
      step(1);
      checks++; if (i0.ax !== 8'h0A || i0.ay !== 8'h00) begin errors++; $display("FAIL single_axes got %h %h want 0a 00", i0.ax, i0.ay); end
      checks++; if (i0.mouse_active !== 1'b1) begin errors++; $display("FAIL single_active got %b want 1", i0.mouse_active); end
      checks++; if (i0.j_out !== 8'hC5) begin errors++; $display("FAIL single_jout got %h want c5", i0.j_out); end
      i0.ps2_mouse[1:0] = 2'b11;
      #1;
      checks++; if (i0.j_out !== 8'hE5) begin errors++; $display("FAIL live_buttons got %h want e5", i0.j_out); end
      pkt(1'b1, 8'hF0, 1'b1, 8'h02, 2'b00);
      step(2);
      checks++; if (i0.ax !== 8'h02 || i0.ay !== 8'hF6) begin errors++; $display("FAIL neg_limit got %h %h want 02 f6", i0.ax, i0.ay); end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 20; i++) begin
         pkt(1'b1, 8'h01, 1'b0, 8'h06, 2'b00);
         step(1);
      end
      step(1);
      checks++; if (i0.ax !== 8'h80 || i0.ay !== 8'h32) begin errors++; $display("FAIL b2b_clamp got %h %h want 80 32", i0.ax, i0.ay); end
      pkt(1'b1, 8'h01, 1'b0, 8'h00, 2'b00);
      step(2);
      checks++; if (i0.ax !== 8'h80 || i0.ay !== 8'h32) begin errors++; $display("FAIL no_wrap got %h %h want 80 32", i0.ax, i0.ay); end
   endtask

   task automatic test_release;
      pkt(1'b0, 8'h28, 1'b0, 8'h28, 2'b01);
      i0.joya = 16'h0100;
      step(1);
      checks++; if (i0.mouse_active !== 1'b0 || i0.ax !== 8'h00 || i0.ay !== 8'h01) begin errors++; $display("FAIL release_pass got act=%b ax=%h ay=%h want 0 00 01", i0.mouse_active, i0.ax, i0.ay); end
      checks++; if (i0.j_out !== 8'hA5) begin errors++; $display("FAIL release_jout got %h want a5", i0.j_out); end
      i0.joya = 16'h0000;
      step(2);
      checks++; if (i0.mouse_active !== 1'b0) begin errors++; $display("FAIL release_discard got %b want 0", i0.mouse_active); end
      pkt(1'b0, 8'h08, 1'b0, 8'h00, 2'b00);
      step(2);
      checks++; if (i0.ax !== 8'h04 || i0.ay !== 8'h00 || i0.mouse_active !== 1'b1) begin errors++; $display("FAIL release_restart got %h %h %b want 04 00 1", i0.ax, i0.ay, i0.mouse_active); end
   endtask

   task automatic test_halt;
      i0.halt = 1'b1;
      step(1);
      i0.halt = 1'b0;
      checks++; if (i0.mouse_active !== 1'b0 || i0.j_out !== 8'hA5 || i0.ax !== 8'h00) begin errors++; $display("FAIL halt_pass got act=%b j=%h ax=%h want 0 a5 00", i0.mouse_active, i0.j_out, i0.ax); end
      pkt(1'b0, 8'h0C, 1'b0, 8'h00, 2'b00);
      step(2);
      checks++; if (i0.ax !== 8'h06) begin errors++; $display("FAIL halt_restart got %h want 06", i0.ax); end
      for (int i = 0; i < 14; i++) begin
         pkt(1'b0, 8'h28, 1'b0, 8'h00, 2'b00);
         step(1);
      end
      step(1);
      checks++; if (i0.ax !== 8'h7F) begin errors++; $display("FAIL pos_clamp got %h want 7f", i0.ax); end
   endtask

   task automatic test_idle;
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(1);
      pkt(1'b0, 8'h28, 1'b0, 8'h00, 2'b00);
      step(2);
      checks++; if (i1.mouse_active !== 1'b1) begin errors++; $display("FAIL idle_enter got %b want 1", i1.mouse_active); end
      step(99);
      checks++; if (i1.mouse_active !== 1'b1) begin errors++; $display("FAIL idle_early got %b want 1", i1.mouse_active); end
      step(1);
      checks++; if (i1.mouse_active !== 1'b0 || i1.ax !== 8'h00) begin errors++; $display("FAIL idle_timeout got act=%b ax=%h want 0 00", i1.mouse_active, i1.ax); end
      pkt(1'b0, 8'h28, 1'b0, 8'h00, 2'b00);
      step(2);
      step(98);
      pkt(1'b0, 8'h28, 1'b0, 8'h00, 2'b00);
      step(2);
      checks++; if (i1.mouse_active !== 1'b1 || i1.ax !== 8'h14) begin errors++; $display("FAIL idle_refresh got act=%b ax=%h want 1 14", i1.mouse_active, i1.ax); end
      step(99);
      checks++; if (i1.mouse_active !== 1'b1) begin errors++; $display("FAIL idle_recount got %b want 1", i1.mouse_active); end
      step(1);
      checks++; if (i1.mouse_active !== 1'b0) begin errors++; $display("FAIL idle_timeout2 got %b want 0", i1.mouse_active); end
      checks++; if (i0.mouse_active !== 1'b1 || i0.ax !== 8'h1E) begin errors++; $display("FAIL no_timeout got act=%b ax=%h want 1 1e", i0.mouse_active, i0.ax); end
   endtask

   task automatic test_reset_strobe;
      pkt(1'b0, 8'h28, 1'b0, 8'h28, 2'b00);
      step(1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(3);
      checks++; if (i0.mouse_active !== 1'b0 || i0.ax !== 8'h00) begin errors++; $display("FAIL reset_midpipe got act=%b ax=%h want 0 00", i0.mouse_active, i0.ax); end
      rst = 1'b1;
      pkt(1'b0, 8'h28, 1'b0, 8'h28, 2'b00);
      step(2);
      rst = 1'b0;
      step(3);
      checks++; if (i0.mouse_active !== 1'b0 || i0.ax !== 8'h00 || i0.ay !== 8'h00) begin errors++; $display("FAIL reset_strobe got act=%b ax=%h ay=%h want 0 00 00", i0.mouse_active, i0.ax, i0.ay); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_release;
      test_halt;
      test_idle;
      test_reset_strobe;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
